mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 multiplexer between four requesters.
- Each requester raises req[k] to own the mux. The block registers a one-hot grant and drives the mux select from it.
- It forwards the selected input to y, qualified by valid.
- Sits in front of the shared mux datapath; replaces free-running select stimulus with a request/grant handshake.

---
 rtl/mux4_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
// It registers a one-hot grant and drives the mux select and the valid flag from that grant.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] y
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam int unsigned CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_TOP = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_TOP);

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_gnt;
  logic [1:0]      r_sel;
  logic            r_valid;

  logic [1:0]      w_idle_win;
  logic [1:0]      w_next_ptr;
  logic [3:0]      w_others;
  logic [1:0]      w_rot_win;
  logic            w_release;
  logic            w_preempt;
  logic [WIDTH-1:0] w_y;

  // First set bit scanning start, start+1, ... mod 4; returns start when empty.
  function automatic logic [1:0] f_pick(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] idx;
    f_pick = start;
    for (int unsigned n = 4; n > 0; n--) begin
      idx = start + 2'(n - 1);
      if (req_v[idx]) f_pick = idx;
    end
  endfunction

  always_comb begin
    w_idle_win = f_pick(req, r_ptr);
    w_next_ptr = r_sel + 2'd1;
    // Masking the owner lets release and preemption share one rotated search.
    w_others   = req & ~r_gnt;
    w_rot_win  = f_pick(w_others, w_next_ptr);
    w_release  = ~req[r_sel];
    w_preempt  = (MAX_HOLD > 0) && req[r_sel] && (r_cnt == CNT_MAX) && (|w_others);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= 4'b0001 << w_idle_win;
            r_sel   <= w_idle_win;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release || w_preempt) begin
            r_ptr <= w_next_ptr;
            r_cnt <= '0;
            if (|w_others) begin
              r_gnt <= 4'b0001 << w_rot_win;
              r_sel <= w_rot_win;
            end else begin
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if ((MAX_HOLD > 0) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_y = '0;
    if (r_valid) begin
      case (r_sel)
        2'd0:    w_y = i0;
        2'd1:    w_y = i1;
        2'd2:    w_y = i2;
        default: w_y = i3;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign y     = w_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized traffic, all scored
// against an owner/pointer reference model of the arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner (-1 = idle), cycles owned so far, rotation pointer, last owner.
  int m_ptr = 0, m_owner = -1, m_held = 0, m_sel = 0;

  mux4_rr_arbiter #(.WIDTH(1), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .sel(sel), .valid(valid), .y(y)
  );

  always #5 clk = ~clk;

  function automatic int pick(int start, logic [3:0] mask);
    for (int off = 0; off < 4; off++) begin
      int k;
      k = (start + off) % 4;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_held = 0; m_sel = 0;
  endtask

  task automatic model_edge();
    int w;
    logic [3:0] others;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      w = pick(m_ptr, req);
      if (w >= 0) begin m_owner = w; m_held = 1; m_sel = w; end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner] || (MAXH > 0 && m_held >= MAXH && others != 4'b0000)) begin
        m_ptr = (m_owner + 1) % 4;
        w = pick(m_ptr, others);
        if (w >= 0) begin m_owner = w; m_held = 1; m_sel = w; end
        else m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [7:0] expv();
    logic [3:0] g;
    logic [3:0] d;
    logic       yy;
    g = 4'b0000;
    d = {i3, i2, i1, i0};
    yy = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      yy = d[m_sel];
    end
    return {g, 2'(m_sel), (m_owner >= 0), yy};
  endfunction

  function automatic logic [7:0] dutv();
    return {gnt, sel, valid, y};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (dutv() !== 8'b0000_00_0_0) begin
      n_err++; $display("FAIL reset_state: got %b want %b (gnt,sel,valid,y)", dutv(), 8'b0000_00_0_0);
    end
    req = 4'b0010; i1 = 1'b1;
    rst = 1'b0;
    step();
    n_vec++;
    if (dutv() !== 8'b0010_01_1_1) begin
      n_err++; $display("FAIL single_grant: got %b want %b", dutv(), 8'b0010_01_1_1);
    end
    req = 4'b0000;
    step();
    n_vec++;
    if (dutv() !== 8'b0000_01_0_0) begin
      n_err++; $display("FAIL single_release: got %b want %b", dutv(), 8'b0000_01_0_0);
    end
    i1 = 1'b0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      n_vec++;
      if (sel !== 2'(order[n]) || gnt !== (4'b0001 << order[n]) || valid !== 1'b1 || dutv() !== expv()) begin
        n_err++; $display("FAIL rr_order[%0d]: got gnt=%b sel=%0d valid=%b want owner %0d", n, gnt, sel, valid, order[n]);
      end
      req = 4'b1111;
      req[order[n]] = 1'b0;
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      n_vec++;
      if (gnt !== 4'b0001 || dutv() !== expv()) begin
        n_err++; $display("FAIL preempt_hold[%0d]: got gnt=%b want 0001", n, gnt);
      end
      step();
    end
    n_vec++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || dutv() !== expv()) begin
      n_err++; $display("FAIL preempt_switch: got gnt=%b sel=%0d want 0100 sel=2", gnt, sel);
    end
    do_reset();
    req = 4'b0001;
    for (int n = 0; n < 12; n++) begin
      step();
      n_vec++;
      if (gnt !== 4'b0001 || valid !== 1'b1) begin
        n_err++; $display("FAIL solo_hold[%0d]: got gnt=%b valid=%b want 0001 1", n, gnt, valid);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    step();
    req = 4'b1001;
    step();
    n_vec++;
    if (gnt !== 4'b1000 || dutv() !== expv()) begin
      n_err++; $display("FAIL wrap_owner3: got gnt=%b want 1000", gnt);
    end
    req = 4'b0001;
    step();
    n_vec++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || dutv() !== expv()) begin
      n_err++; $display("FAIL wrap_to0: got gnt=%b sel=%0d want 0001 sel=0", gnt, sel);
    end
    do_reset();
    req = 4'b1000;
    step();
    req = 4'b0011;
    step();
    n_vec++;
    if (gnt !== 4'b0001 || dutv() !== expv()) begin
      n_err++; $display("FAIL wrap_ptr0_over1: got gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_async_reset_mid_grant();
    do_reset();
    req = 4'b0100; i2 = 1'b1;
    step();
    n_vec++;
    if (gnt !== 4'b0100 || y !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got gnt=%b y=%b want 0100 1", gnt, y);
    end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (dutv() !== 8'b0000_00_0_0) begin
      n_err++; $display("FAIL mid_reset: got %b want %b", dutv(), 8'b0000_00_0_0);
    end
    req = 4'b1111;
    rst = 1'b0;
    step();
    n_vec++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || dutv() !== expv()) begin
      n_err++; $display("FAIL mid_regrant: got gnt=%b sel=%0d want 0001 0", gnt, sel);
    end
    i2 = 1'b0;
  endtask

  task automatic test_datapath();
    logic [2:0] pat;
    pat = 3'b010;
    do_reset();
    req = 4'b0010;
    step();
    for (int n = 0; n < 3; n++) begin
      i1 = pat[n];
      i0 = 1'($urandom_range(0, 1));
      i2 = 1'($urandom_range(0, 1));
      i3 = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (y !== pat[n] || dutv() !== expv()) begin
        n_err++; $display("FAIL data_follow[%0d]: got y=%b want %b", n, y, pat[n]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      i0 = 1'($urandom_range(0, 1));
      i1 = 1'($urandom_range(0, 1));
      i2 = 1'($urandom_range(0, 1));
      i3 = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
      #1;
      n_vec++;
      if (dutv() !== expv()) begin
        n_err++; $display("FAIL rand_pre[%0d]: got %b want %b (gnt,sel,valid,y)", n, dutv(), expv());
      end
      step();
      rst = 1'b0;
      n_vec++;
      if (dutv() !== expv()) begin
        n_err++; $display("FAIL rand_post[%0d]: got %b want %b (gnt,sel,valid,y) req=%b", n, dutv(), expv(), req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_preempt();
    test_wrap();
    test_async_reset_mid_grant();
    test_datapath();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
